// File: rtl/rom_fetch_pkg.sv
// Shared constants, FSM state type and read-data formatting for rom_fetch_bridge.
// Defining ROM_PREFETCH_EN adds the PREF state.
package rom_fetch_pkg;

  localparam int unsigned DEF_ADDR_W = 24;
  localparam int unsigned DEF_DATA_W = 16;

`ifdef ROM_PREFETCH_EN
  typedef enum logic [1:0] { ST_IDLE, ST_FETCH, ST_PREF } fetch_state_e;
`else
  typedef enum logic [1:0] { ST_IDLE, ST_FETCH } fetch_state_e;
`endif

  // Byte reads return the addressed byte on both halves of the bus.
  function automatic logic [15:0] fmt_q(input logic [15:0] i_word,
                                        input logic        i_is_word,
                                        input logic        i_odd);
    logic [7:0] w_byte;
    w_byte = i_odd ? i_word[15:8] : i_word[7:0];
    return i_is_word ? i_word : {w_byte, w_byte};
  endfunction

endpackage

// File: rtl/rom_fetch_entry.sv
// One buffered ROM word: tag, data and valid bit with a tag-compare output.
// Invalidate has priority over a same-cycle load.
module rom_fetch_entry
  import rom_fetch_pkg::*;
#(
  parameter int unsigned TAG_W  = DEF_ADDR_W - 1,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              MCLK,
  input  logic              RESET_N,
  input  logic              i_inval,
  input  logic              i_load,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_cmp_tag,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else begin
      if (i_inval) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end
      if (i_load) begin
        r_tag  <= i_tag;
        r_data <= i_data;
      end
    end
  end

  assign o_hit  = r_valid && (r_tag == i_cmp_tag);
  assign o_data = r_data;

endmodule

// File: rtl/rom_fetch_bridge.sv
// Cartridge ROM read buffer: serves hits from buffered words, fetches misses from memory.
// Defining ROM_PREFETCH_EN adds a second entry filled with the word after each demand fill.
module rom_fetch_bridge
  import rom_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              MCLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] ROM_ADDR,
  input  logic              ROM_CE_N,
  input  logic              ROM_OE_N,
  input  logic              ROM_WORD,
  output logic [DATA_W-1:0] ROM_Q,
  input  logic              INVAL,
  output logic              MEM_REQ,
  output logic [ADDR_W-2:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              BUSY
);

  localparam int unsigned TAG_W = ADDR_W - 1;

  fetch_state_e      r_state, w_nstate;
  logic              r_req, w_nreq;
  logic [TAG_W-1:0]  r_addr, w_naddr;
  logic [DATA_W-1:0] r_q, w_nq;
  logic              r_word, w_nword;
  logic              r_odd, w_nodd;

  logic              w_rd, w_hit, w_hit0, w_hit1, w_load0;
  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] w_data0, w_data1, w_hit_data;

  assign w_rd       = ~ROM_CE_N & ~ROM_OE_N;
  assign w_tag      = ROM_ADDR[ADDR_W-1:1];
  assign w_hit      = w_rd & (w_hit0 | w_hit1);
  assign w_hit_data = w_hit0 ? w_data0 : w_data1;

  rom_fetch_entry #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_demand (
    .MCLK      (MCLK),
    .RESET_N   (RESET_N),
    .i_inval   (INVAL),
    .i_load    (w_load0),
    .i_tag     (r_addr),
    .i_data    (MEM_DATA),
    .i_cmp_tag (w_tag),
    .o_hit     (w_hit0),
    .o_data    (w_data0)
  );

`ifdef ROM_PREFETCH_EN
  logic w_load1;

  rom_fetch_entry #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_pref (
    .MCLK      (MCLK),
    .RESET_N   (RESET_N),
    .i_inval   (INVAL),
    .i_load    (w_load1),
    .i_tag     (r_addr),
    .i_data    (MEM_DATA),
    .i_cmp_tag (w_tag),
    .o_hit     (w_hit1),
    .o_data    (w_data1)
  );
`else
  assign w_hit1  = 1'b0;
  assign w_data1 = '0;
`endif

  always_comb begin
    w_nstate = r_state;
    w_nreq   = r_req;
    w_naddr  = r_addr;
    w_nq     = r_q;
    w_nword  = r_word;
    w_nodd   = r_odd;
    w_load0  = 1'b0;
`ifdef ROM_PREFETCH_EN
    w_load1  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_nq = fmt_q(w_hit_data, ROM_WORD, ROM_ADDR[0]);
        end else if (w_rd) begin
          w_nstate = ST_FETCH;
          w_nreq   = 1'b1;
          w_naddr  = w_tag;
          w_nword  = ROM_WORD;
          w_nodd   = ROM_ADDR[0];
        end
      end
      ST_FETCH: begin
        // Byte lane and width come from the access that caused the miss.
        if (MEM_ACK) begin
          w_load0 = 1'b1;
          w_nq    = fmt_q(MEM_DATA, r_word, r_odd);
          w_nreq  = 1'b0;
`ifdef ROM_PREFETCH_EN
          w_nstate = ST_PREF;
          w_naddr  = r_addr + {{(TAG_W-1){1'b0}}, 1'b1};
`else
          w_nstate = ST_IDLE;
`endif
        end
      end
`ifdef ROM_PREFETCH_EN
      ST_PREF: begin
        // Request re-raised one cycle after the demand ack; misses wait here.
        if (w_hit) begin
          w_nq = fmt_q(w_hit_data, ROM_WORD, ROM_ADDR[0]);
        end
        if (!r_req) begin
          w_nreq = 1'b1;
        end else if (MEM_ACK) begin
          w_load1  = 1'b1;
          w_nreq   = 1'b0;
          w_nstate = ST_IDLE;
        end
      end
`endif
      default: begin
        w_nstate = ST_IDLE;
        w_nreq   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_q     <= '0;
      r_word  <= 1'b0;
      r_odd   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_req   <= w_nreq;
      r_addr  <= w_naddr;
      r_q     <= w_nq;
      r_word  <= w_nword;
      r_odd   <= w_nodd;
    end
  end

  assign MEM_REQ  = r_req;
  assign MEM_ADDR = r_addr;
  assign ROM_Q    = r_q;
  assign BUSY     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rom_fetch_bridge.sv
// Directed bench for rom_fetch_bridge with a behavioural buffer model and a responding memory.
// Build with ROM_PREFETCH_EN defined to exercise the prefetch entry.
module tb_rom_fetch_bridge;

`ifdef ROM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam int P = PF ? 1 : 0;

  logic        MCLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [23:0] ROM_ADDR = '0;
  logic        ROM_CE_N = 1'b1;
  logic        ROM_OE_N = 1'b1;
  logic        ROM_WORD = 1'b1;
  logic [15:0] ROM_Q;
  logic        INVAL = 1'b0;
  logic        MEM_REQ;
  logic [22:0] MEM_ADDR;
  logic        MEM_ACK = 1'b0;
  logic [15:0] MEM_DATA = '0;
  logic        BUSY;

  rom_fetch_bridge #(.ADDR_W(24), .DATA_W(16)) dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .ROM_ADDR(ROM_ADDR), .ROM_CE_N(ROM_CE_N),
    .ROM_OE_N(ROM_OE_N), .ROM_WORD(ROM_WORD), .ROM_Q(ROM_Q), .INVAL(INVAL),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .BUSY(BUSY)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memfn(input logic [22:0] a);
    if (a == 23'h004000) return 16'hA55A;
    return {a[7:0] ^ a[22:15] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  function automatic logic [15:0] fmtq(input logic [15:0] w, input logic word, input logic odd);
    if (word) return w;
    if (odd) return {w[15:8], w[15:8]};
    return {w[7:0], w[7:0]};
  endfunction

  // Memory: acks any request after lat sampled cycles; can inject a stray ack.
  int lat = 2;
  int wcnt = 0;
  int spur_req = 0;
  int spur_done = 0;
  always @(negedge MCLK) begin
    if (MEM_ACK) begin
      MEM_ACK = 1'b0;
      wcnt = 0;
    end else if (spur_req != spur_done) begin
      spur_done = spur_req;
      MEM_ACK = 1'b1;
      MEM_DATA = 16'hDEAD;
    end else if (MEM_REQ) begin
      wcnt++;
      if (wcnt >= lat) begin
        MEM_ACK = 1'b1;
        MEM_DATA = memfn(MEM_ADDR);
      end
    end else begin
      wcnt = 0;
    end
  end

  // Log of every request raised (address at the first cycle it is seen).
  logic [22:0] rlog[$];
  bit prev_req = 1'b0;
  always @(posedge MCLK) begin
    if (MEM_REQ && !prev_req) rlog.push_back(MEM_ADDR);
    prev_req = MEM_REQ;
  end

  // Model: ph 0 idle, 1 demand outstanding, 2 prefetch about to issue, 3 prefetch outstanding.
  int          ph = 0;
  logic [15:0] m_q = '0;
  logic [22:0] m_addr = '0;
  logic        m_word = 1'b0, m_odd = 1'b0;
  logic        mv0 = 1'b0, mv1 = 1'b0;
  logic [22:0] mt0 = '0, mt1 = '0;
  logic [15:0] md0 = '0, md1 = '0;
  logic        m_rd, h0, h1;
  logic [22:0] m_t;
  always @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ph = 0; m_q = '0; m_addr = '0; mv0 = 1'b0; mv1 = 1'b0;
    end else begin
      m_rd = !ROM_CE_N && !ROM_OE_N;
      m_t  = ROM_ADDR[23:1];
      h0 = m_rd && mv0 && (mt0 == m_t);
      h1 = m_rd && mv1 && (mt1 == m_t);
      case (ph)
        0: if (m_rd) begin
             if (h0 || h1) m_q = fmtq(h0 ? md0 : md1, ROM_WORD, ROM_ADDR[0]);
             else begin ph = 1; m_addr = m_t; m_word = ROM_WORD; m_odd = ROM_ADDR[0]; end
           end
        1: if (MEM_ACK) begin
             m_q = fmtq(MEM_DATA, m_word, m_odd);
             mt0 = m_addr; md0 = MEM_DATA; mv0 = 1'b1;
             if (PF) begin ph = 2; m_addr = m_addr + 23'd1; end
             else ph = 0;
           end
        default: begin
          if (h0 || h1) m_q = fmtq(h0 ? md0 : md1, ROM_WORD, ROM_ADDR[0]);
          if (ph == 2) ph = 3;
          else if (MEM_ACK) begin mt1 = m_addr; md1 = MEM_DATA; mv1 = 1'b1; ph = 0; end
        end
      endcase
      if (INVAL) begin mv0 = 1'b0; mv1 = 1'b0; end
    end
  end

  always @(negedge MCLK) begin
    if (RESET_N) begin
      chk("model_rom_q", 32'(ROM_Q), 32'(m_q));
      chk("model_mem_req", 32'(MEM_REQ), 32'(ph == 1 || ph == 3));
      chk("model_busy", 32'(BUSY), 32'(ph != 0));
      if (ph == 1 || ph == 3) chk("model_mem_addr", 32'(MEM_ADDR), 32'(m_addr));
    end
  end

  task automatic rd(input logic [23:0] a, input logic word);
    ROM_ADDR = a; ROM_WORD = word; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
  endtask

  task automatic noacc();
    ROM_CE_N = 1'b1; ROM_OE_N = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    do begin @(negedge MCLK); n++; end while (BUSY && n < maxc);
    chk("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  initial begin
    int n0, n1;
    bit got;
    #1 RESET_N = 1'b0;
    #3;
    chk("rst_rom_q", 32'(ROM_Q), 32'h0);
    chk("rst_mem_req", 32'(MEM_REQ), 32'h0);
    chk("rst_mem_addr", 32'(MEM_ADDR), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    cyc(2);
    RESET_N = 1'b1;
    cyc(2);

    // Word miss at 0x008000.
    n0 = rlog.size();
    rd(24'h008000, 1'b1);
    cyc(1);
    chk("miss_req_rise", 32'(MEM_REQ), 32'h1);
    wait_idle(30);
    chk("miss_mem_addr", 32'(rlog[n0]), 32'h004000);
    chk("miss_rom_q", 32'(ROM_Q), 32'hA55A);

    // Byte hit on the odd lane.
    n0 = rlog.size();
    rd(24'h008001, 1'b0);
    cyc(1);
    chk("hit_byte_q", 32'(ROM_Q), 32'hA5A5);
    cyc(2);
    chk("hit_no_req", 32'(rlog.size()), 32'(n0));

    // Idle bus holds data; a stray ack while idle is ignored.
    noacc();
    ROM_ADDR = 24'h123456;
    spur_req++;
    cyc(4);
    chk("hold_rom_q", 32'(ROM_Q), 32'hA5A5);
    chk("stray_ack_busy", 32'(BUSY), 32'h0);

    // Plain invalidate forces a refetch.
    INVAL = 1'b1;
    cyc(1);
    INVAL = 1'b0;
    n0 = rlog.size();
    rd(24'h008000, 1'b1);
    wait_idle(30);
    chk("inval_refetch", 32'(rlog.size()), 32'(n0 + 1 + P));
    noacc();
    cyc(1);

    // Address change during FETCH does not abort the request.
    n0 = rlog.size();
    rd(24'h020000, 1'b1);
    cyc(1);
    ROM_ADDR = 24'h010000;
    wait_idle(30);
    chk("midchg_first_q", 32'(ROM_Q), 32'(memfn(23'h010000)));
    wait_idle(30);
    chk("midchg_first_addr", 32'(rlog[n0]), 32'h010000);
    chk("midchg_second_addr", 32'(rlog[n0 + 1 + P]), 32'h008000);
    noacc();
    cyc(1);

    // INVAL coinciding with MEM_ACK: data returned, entry left invalid.
    rd(24'h060000, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge MCLK);
      #1;
      if (MEM_ACK) got = 1'b1;
    end
    chk("collide_ack_seen", 32'(got), 32'h1);
    INVAL = 1'b1;
    cyc(1);
    INVAL = 1'b0;
    noacc();
    chk("collide_rom_q", 32'(ROM_Q), 32'(memfn(23'h030000)));
    wait_idle(30);
    n0 = rlog.size();
    rd(24'h060000, 1'b1);
    wait_idle(30);
    chk("collide_reread_req", 32'(rlog[n0]), 32'h030000);
    noacc();
    cyc(1);

    // Last word of the address space; prefetch wraps to word 0.
    n0 = rlog.size();
    rd(24'hFFFFFE, 1'b1);
    wait_idle(30);
    chk("top_miss_addr", 32'(rlog[n0]), 32'h7FFFFF);
    chk("top_miss_q", 32'(ROM_Q), 32'(memfn(23'h7FFFFF)));
`ifdef ROM_PREFETCH_EN
    chk("pref_wrap_addr", 32'(rlog[n0 + 1]), 32'h000000);
    n1 = rlog.size();
    rd(24'h000000, 1'b1);
    cyc(3);
    chk("pref_hit_no_req", 32'(rlog.size()), 32'(n1));
    chk("pref_hit_q", 32'(ROM_Q), 32'h5AC3);
`endif
    noacc();
    cyc(1);

    // Reset during FETCH clears outputs asynchronously.
    rd(24'h0A0000, 1'b1);
    cyc(1);
    chk("rst_mid_req_before", 32'(MEM_REQ), 32'h1);
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(MEM_REQ), 32'h0);
    chk("rst_mid_rom_q", 32'(ROM_Q), 32'h0);
    chk("rst_mid_busy", 32'(BUSY), 32'h0);
    noacc();
    cyc(2);
    RESET_N = 1'b1;
    cyc(3);
    chk("post_rst_no_req", 32'(MEM_REQ), 32'h0);
    n0 = rlog.size();
    rd(24'h008000, 1'b1);
    wait_idle(30);
    chk("post_rst_refetch", 32'(rlog[n0]), 32'h004000);
    chk("post_rst_q", 32'(ROM_Q), 32'hA55A);
    noacc();
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/rom_fetch_bridge.md
ROM_FETCH_BRIDGE -- requirements
Module: rom_fetch_bridge

Interface
REQ-001 Parameter ADDR_W, default 24, SHALL set the byte-address width of the cartridge ROM bus.
REQ-002 Parameter DATA_W, default 16, SHALL set the memory word width; only 16 is supported.
REQ-003 MCLK  in  1  SHALL be the single clock for all logic.
REQ-004 RESET_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 ROM_ADDR  in  ADDR_W  SHALL be the byte address from the active cartridge mapper.
REQ-006 ROM_CE_N  in  1  SHALL be the mapper ROM chip-enable, active low.
REQ-007 ROM_OE_N  in  1  SHALL be the mapper ROM output-enable, active low.
REQ-008 ROM_WORD  in  1  SHALL be 1 for a 16-bit access and 0 for a byte access.
REQ-009 ROM_Q  out  16  SHALL be the registered read data returned to the mapper.
REQ-010 INVAL  in  1  SHALL invalidate all buffered data, for example on ROM reload.
REQ-011 MEM_REQ  out  1  SHALL be the level request to the memory controller.
REQ-012 MEM_ADDR  out  ADDR_W-1  SHALL be the word address of the pending request.
REQ-013 MEM_ACK  in  1  SHALL be a one-cycle pulse meaning MEM_DATA is valid.
REQ-014 MEM_DATA  in  16  SHALL be the read word from memory.
REQ-015 BUSY  out  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-016 A read access SHALL be ROM_CE_N=0 and ROM_OE_N=0, sampled on the MCLK rising edge.
REQ-017 A hit SHALL be a read access where ROM_ADDR[ADDR_W-1:1] equals a valid buffered tag.
- On a hit, ROM_Q SHALL update on the next edge.
- On a hit, no memory request SHALL be issued.
REQ-018 FSM states SHALL be IDLE, FETCH and PREF.
- PREF SHALL exist only when ROM_PREFETCH_EN is defined.
REQ-019 IDLE SHALL move to FETCH on a read-access miss.
- On that same edge, MEM_ADDR SHALL load ROM_ADDR[ADDR_W-1:1] and MEM_REQ SHALL be set to 1.
REQ-020 In FETCH, MEM_REQ and MEM_ADDR SHALL stay stable until MEM_ACK.
- On MEM_ACK, the FSM SHALL capture MEM_DATA and tag, set valid, clear MEM_REQ and update ROM_Q.
- The FSM SHALL then go to IDLE, or to PREF when prefetch is enabled.
REQ-021 Miss latency: ROM_Q SHALL hold the new data on the edge that samples MEM_ACK.
- The minimum miss latency SHALL be 2 cycles from access detection.
REQ-022 Byte access (ROM_WORD=0):
- ROM_Q[7:0] SHALL be word[15:8] when ROM_ADDR[0]=1, and word[7:0] otherwise.
- ROM_Q[15:8] SHALL replicate ROM_Q[7:0].
REQ-023 ROM_Q SHALL hold its last value while no read access is active.
REQ-024 A change of ROM_ADDR or ROM_CE_N during FETCH SHALL NOT abort the request.
- The new access SHALL be re-evaluated in IDLE on the cycle after completion.
REQ-025 INVAL SHALL clear every valid bit on the next edge.
- If INVAL and MEM_ACK occur on the same cycle, INVAL SHALL win and the entry SHALL stay invalid.
- ROM_Q SHALL still update in that case.
REQ-026 MEM_ACK arriving while in IDLE SHALL be ignored.

Reset
REQ-027 While RESET_N=0, the block SHALL hold:
- FSM in IDLE;
- MEM_REQ, MEM_ADDR and ROM_Q at 0;
- BUSY at 0;
- all valid bits at 0.
REQ-028 Reset asserted mid-request SHALL drop MEM_REQ immediately.
- After reset release, no outstanding transaction SHALL be assumed.

Configuration
REQ-029 With ROM_PREFETCH_EN defined, the block SHALL hold two entries, demand and prefetch.
- After each demand fill, PREF SHALL request tag+1, wrapping from all-ones to 0, into the other entry.
- A demand miss arriving during PREF SHALL wait for the PREF ack.
- A hit SHALL match either entry.
REQ-030 Without ROM_PREFETCH_EN, the block SHALL hold a single entry and PREF SHALL be absent.

Structure
REQ-031 Package rom_fetch_pkg SHALL hold the FSM state enum and the ADDR_W and DATA_W default constants.
REQ-032 Sub-module rom_fetch_entry SHALL hold one tag/data/valid entry.
- It SHALL provide a compare output.
- It SHALL be instantiated once, or twice when prefetch is enabled.

Verification
REQ-033 Miss:
- Stimulus: reset, then read at ROM_ADDR=0x008000, word access, with MEM_ACK on cycle 3 carrying 0xA55A.
- Required response: MEM_ADDR=0x004000, MEM_REQ high for cycles 1-3, ROM_Q=0xA55A.
REQ-034 Hit with byte select:
- Stimulus: repeat read at 0x008001 with ROM_WORD=0.
- Required response: no MEM_REQ, ROM_Q=0xA5A5 one cycle later.
REQ-035 Mid-request address change:
- Stimulus: ROM_ADDR changes to 0x010000 during FETCH.
- Required response: the first fill completes, then MEM_ADDR=0x008000 is requested.
REQ-036 INVAL colliding with MEM_ACK:
- Stimulus: INVAL and MEM_ACK in the same cycle, then a reread of the same address.
- Required response: a new MEM_REQ is issued.
REQ-037 Prefetch with wrap:
- Stimulus: with ROM_PREFETCH_EN, read 0xFFFFFE.
- Required response: a PREF request to MEM_ADDR=0x000000, and a later read of 0x000000 hits with no request.
REQ-038 Reset mid-request:
- Stimulus: RESET_N low during FETCH.
- Required response: MEM_REQ=0 and ROM_Q=0 asynchronously, and BUSY=0.
